tx_code_group_gen: RTL and testbench
====================================

# tx_code_group_gen

Clause 36 PCS transmit code-group sequencer for the 1000BASE-X transmit path. It takes one ordered-set request per ordered set from the transmit ordered-set machine, plus TXD, and emits one 10-bit code group per GTX_CLK. It owns running disparity and the even/odd code-group alignment. It drives tx_even and TX_OSET_indicate back to the ordered-set machine, which advances tx_o_set only on TX_OSET_indicate.

## Interface
Parameters:
- none

Ports:
- GTX_CLK  in  1  transmit clock; every output is registered on its rising edge.
- mr_main_reset  in  1  asynchronous active-low reset.
- tx_o_set  in  3  ordered-set request (encoding in the Structure section).
- TXD  in  8  data octet; encoded only when tx_o_set = DATA.
- tx_code_group  out  10  code group, bit order {a,b,c,d,e,i,f,g,h,j}, with a in bit 9.
- tx_even  out  1  1 when the current code group is in an even position.
- TX_OSET_indicate  out  1  1 on the cycle that outputs the last code group of an ordered set.
- tx_disparity  out  1  running disparity after the current code group (1 = positive).

## Operation
- States: GEN (decode request), IDLE_K (second half of /I/).
- In GEN, tx_o_set and TXD are sampled each cycle.
  - START, END, CARRIER_EXT, ERROR send K27.7, K29.7, K23.7 or K30.7.
  - DATA sends the D code for TXD.
  - For each of these: tx_even toggles, TX_OSET_indicate = 1, state stays GEN.
- IDLE in GEN sends K28.5 with tx_even forced to 1 and TX_OSET_indicate = 0, then goes to IDLE_K.
- IDLE_K sends the second code group, sets tx_even = 0 and TX_OSET_indicate = 1, then returns to GEN.
  - If running disparity was positive when K28.5 was sent, the second code group is D5.6 (/I1/).
  - Otherwise it is D16.2 (/I2/).
  - In both cases running disparity is negative after the IDLE completes.
- In IDLE_K, tx_o_set and TXD are ignored.
- Every code group is encoded using the current running disparity. Running disparity is updated per the 8b/10b rules on every cycle (6b and 4b sub-block rules).
- Reserved tx_o_set codes (6, 7) are treated as ERROR (K30.7).
- tx_o_set arriving in IDLE_K is not buffered. Upstream holds its next value until it sees TX_OSET_indicate.

## Timing
- Latency: a request sampled at edge N appears on tx_code_group after edge N. IDLE occupies edges N and N+1.
- Throughput: one ordered set per cycle, except IDLE, which takes two cycles.
- Reset values (asynchronous):
  - tx_code_group = 10'h000
  - tx_even = 0
  - TX_OSET_indicate = 0
  - running disparity negative (tx_disparity = 0)
  - state GEN
- The first request is sampled at the first rising edge after reset deasserts.
- Reset asserted in IDLE_K aborts the idle. No partial /I/ completes, and all outputs return to reset values immediately.
- tx_even toggles on every output cycle except the K28.5 of an IDLE, which forces it to 1. Consecutive IDLEs therefore alternate 1,0,1,0.

## Structure
Shared package `pcs_tx_pkg` holds:
- the tx_o_set encoding: IDLE=0, START=1, DATA=2, END=3, CARRIER_EXT=4, ERROR=5;
- the K-code constants K28.5, K27.7, K29.7, K23.7, K30.7, in both RD- and RD+ forms.

Sub-module `encoder_8b10b` is combinational. Inputs: data_in[7:0], is_k, rd_in. Outputs: code_out[9:0], rd_out. The disparity register lives in tx_code_group_gen.

## Test plan
- **Continuous IDLE after reset.** Output alternates 10'h0FA (K28.5-, even=1, ind=0) and 10'h245 (D16.2+, even=0, ind=1). tx_disparity alternates 1,0.
- **IDLE, START, DATA ×4 (TXD 01, 02, 03, 43), END, then IDLE.**
  - K27.7 from RD- appears as 10'h368, with TX_OSET_indicate=1 on every non-K28.5 cycle and tx_even toggling every cycle.
  - Every code group matches a reference 8b/10b model with the same disparity.
  - The next IDLE's K28.5 has even=1.
- **Force positive disparity before IDLE** (DATA 8'h00 from RD+ leaves RD+). The IDLE is 10'h305 then 10'h296 (/I1/), ending with RD negative.
- **ERROR, and reserved codes 6 and 7.** Each outputs K30.7 for the current disparity, with ind=1.
- **Reset pulse during IDLE_K.** Outputs go to 10'h000/0/0/0 without waiting for a clock. After release, the first IDLE starts cleanly with 10'h0FA.
- **Change tx_o_set to START during IDLE_K.** It is ignored that cycle. K27.7 is output on the following cycle.

Source files
------------

// File: rtl/pcs_tx_pkg.sv
// Shared definitions for the 1000BASE-X PCS transmit code-group path:
// ordered-set request encoding, state type and 8b/10b special-code constants.
package pcs_tx_pkg;

    localparam int unsigned OSET_W  = 3;
    localparam int unsigned OCTET_W = 8;
    localparam int unsigned CG_W    = 10;

    typedef enum logic [OSET_W-1:0] {
        OSET_IDLE   = 3'd0,
        OSET_START  = 3'd1,
        OSET_DATA   = 3'd2,
        OSET_END    = 3'd3,
        OSET_CEXT   = 3'd4,
        OSET_ERROR  = 3'd5
    } tx_oset_e;

    typedef enum logic {
        ST_GEN    = 1'b0,
        ST_IDLE_K = 1'b1
    } tx_state_e;

    // Octet values of the special and idle data characters
    localparam logic [OCTET_W-1:0] K28_5_OCTET = 8'hBC;
    localparam logic [OCTET_W-1:0] K27_7_OCTET = 8'hFB;
    localparam logic [OCTET_W-1:0] K29_7_OCTET = 8'hFD;
    localparam logic [OCTET_W-1:0] K23_7_OCTET = 8'hF7;
    localparam logic [OCTET_W-1:0] K30_7_OCTET = 8'hFE;
    localparam logic [OCTET_W-1:0] D5_6_OCTET  = 8'hC5;
    localparam logic [OCTET_W-1:0] D16_2_OCTET = 8'h50;

    // Code groups {a,b,c,d,e,i,f,g,h,j}, RD- and RD+ forms
    localparam logic [CG_W-1:0] K28_5_RDN = 10'h0FA;
    localparam logic [CG_W-1:0] K28_5_RDP = 10'h305;
    localparam logic [CG_W-1:0] K27_7_RDN = 10'h368;
    localparam logic [CG_W-1:0] K27_7_RDP = 10'h097;
    localparam logic [CG_W-1:0] K29_7_RDN = 10'h2E8;
    localparam logic [CG_W-1:0] K29_7_RDP = 10'h117;
    localparam logic [CG_W-1:0] K23_7_RDN = 10'h3A8;
    localparam logic [CG_W-1:0] K23_7_RDP = 10'h057;
    localparam logic [CG_W-1:0] K30_7_RDN = 10'h1E8;
    localparam logic [CG_W-1:0] K30_7_RDP = 10'h217;

    // Special character for a single-code-group ordered set; unknown codes become /V/
    function automatic logic [OCTET_W-1:0] oset_k_octet(input logic [OSET_W-1:0] oset);
        case (oset)
            OSET_START: return K27_7_OCTET;
            OSET_END:   return K29_7_OCTET;
            OSET_CEXT:  return K23_7_OCTET;
            default:    return K30_7_OCTET;
        endcase
    endfunction

endpackage

// File: rtl/tx_code_group_gen_if.sv
// Link between the transmit ordered-set machine and the code-group sequencer.
interface tx_code_group_gen_if;
    import pcs_tx_pkg::*;

    logic [OSET_W-1:0]  tx_o_set;
    logic [OCTET_W-1:0] TXD;
    logic [CG_W-1:0]    tx_code_group;
    logic               tx_even;
    logic               TX_OSET_indicate;
    logic               tx_disparity;

    modport master (
        output tx_o_set, TXD,
        input  tx_code_group, tx_even, TX_OSET_indicate, tx_disparity
    );

    modport slave (
        input  tx_o_set, TXD,
        output tx_code_group, tx_even, TX_OSET_indicate, tx_disparity
    );
endinterface

// File: rtl/encoder_8b10b.sv
// Combinational 8b/10b encoder: 5b/6b and 3b/4b sub-blocks plus the special K codes.
module encoder_8b10b
    import pcs_tx_pkg::*;
(
    input  logic [OCTET_W-1:0] data_in,
    input  logic               is_k,
    input  logic               rd_in,
    output logic [CG_W-1:0]    code_out,
    output logic               rd_out
);

    logic [4:0]      w_x;
    logic [2:0]      w_y;
    logic [5:0]      w_6b_n;
    logic [5:0]      w_6b;
    logic            w_rd_mid;
    logic [3:0]      w_4b_n;
    logic [3:0]      w_4b;
    logic            w_rd_d;
    logic            w_alt7;
    logic [CG_W-1:0] w_k_code;
    logic            w_rd_k;

    assign w_x = data_in[4:0];
    assign w_y = data_in[7:5];

    // RD- column of the 5b/6b table (abcdei)
    always_comb begin : p_6b_table
        w_6b_n = 6'b100111;
        case (w_x)
            5'd0:  w_6b_n = 6'b100111;
            5'd1:  w_6b_n = 6'b011101;
            5'd2:  w_6b_n = 6'b101101;
            5'd3:  w_6b_n = 6'b110001;
            5'd4:  w_6b_n = 6'b110101;
            5'd5:  w_6b_n = 6'b101001;
            5'd6:  w_6b_n = 6'b011001;
            5'd7:  w_6b_n = 6'b111000;
            5'd8:  w_6b_n = 6'b111001;
            5'd9:  w_6b_n = 6'b100101;
            5'd10: w_6b_n = 6'b010101;
            5'd11: w_6b_n = 6'b110100;
            5'd12: w_6b_n = 6'b001101;
            5'd13: w_6b_n = 6'b101100;
            5'd14: w_6b_n = 6'b011100;
            5'd15: w_6b_n = 6'b010111;
            5'd16: w_6b_n = 6'b011011;
            5'd17: w_6b_n = 6'b100011;
            5'd18: w_6b_n = 6'b010011;
            5'd19: w_6b_n = 6'b110010;
            5'd20: w_6b_n = 6'b001011;
            5'd21: w_6b_n = 6'b101010;
            5'd22: w_6b_n = 6'b011010;
            5'd23: w_6b_n = 6'b111010;
            5'd24: w_6b_n = 6'b110011;
            5'd25: w_6b_n = 6'b100110;
            5'd26: w_6b_n = 6'b010110;
            5'd27: w_6b_n = 6'b110110;
            5'd28: w_6b_n = 6'b001110;
            5'd29: w_6b_n = 6'b101110;
            5'd30: w_6b_n = 6'b011110;
            default: w_6b_n = 6'b101011;
        endcase
    end

    // RD+ form is the complement for unbalanced codes and for D.07
    always_comb begin : p_6b_rd
        w_6b     = w_6b_n;
        w_rd_mid = rd_in;
        if ($countones(w_6b_n) != 3) begin
            w_6b     = rd_in ? ~w_6b_n : w_6b_n;
            w_rd_mid = ~rd_in;
        end else if (w_x == 5'd7) begin
            w_6b = rd_in ? ~w_6b_n : w_6b_n;
        end
    end

    // D.x.A7 avoids a run of five identical bits across the sub-block boundary
    assign w_alt7 = (w_y == 3'd7) &&
                    ((!w_rd_mid && (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) ||
                     ( w_rd_mid && (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)));

    always_comb begin : p_4b_table
        w_4b_n = 4'b1011;
        case (w_y)
            3'd0: w_4b_n = 4'b1011;
            3'd1: w_4b_n = 4'b1001;
            3'd2: w_4b_n = 4'b0101;
            3'd3: w_4b_n = 4'b1100;
            3'd4: w_4b_n = 4'b1101;
            3'd5: w_4b_n = 4'b1010;
            3'd6: w_4b_n = 4'b0110;
            default: w_4b_n = w_alt7 ? 4'b0111 : 4'b1110;
        endcase
    end

    always_comb begin : p_4b_rd
        w_4b   = w_4b_n;
        w_rd_d = w_rd_mid;
        if ($countones(w_4b_n) != 2) begin
            w_4b   = w_rd_mid ? ~w_4b_n : w_4b_n;
            w_rd_d = ~w_rd_mid;
        end else if (w_y == 3'd3) begin
            w_4b = w_rd_mid ? ~w_4b_n : w_4b_n;
        end
    end

    // Special codes; any unsupported K octet is sent as /V/
    always_comb begin : p_k_code
        w_k_code = rd_in ? K30_7_RDP : K30_7_RDN;
        case (data_in)
            K28_5_OCTET: w_k_code = rd_in ? K28_5_RDP : K28_5_RDN;
            K27_7_OCTET: w_k_code = rd_in ? K27_7_RDP : K27_7_RDN;
            K29_7_OCTET: w_k_code = rd_in ? K29_7_RDP : K29_7_RDN;
            K23_7_OCTET: w_k_code = rd_in ? K23_7_RDP : K23_7_RDN;
            default:     w_k_code = rd_in ? K30_7_RDP : K30_7_RDN;
        endcase
    end

    assign w_rd_k   = ($countones(w_k_code) == 5) ? rd_in : ~rd_in;
    assign code_out = is_k ? w_k_code : {w_6b, w_4b};
    assign rd_out   = is_k ? w_rd_k : w_rd_d;

endmodule

// File: rtl/tx_code_group_gen.sv
// 1000BASE-X PCS transmit code-group sequencer: turns ordered-set requests into
// one code group per GTX_CLK while tracking running disparity and even/odd alignment.
module tx_code_group_gen
    import pcs_tx_pkg::*;
(
    input  logic               GTX_CLK,
    input  logic               mr_main_reset,
    tx_code_group_gen_if.slave tx_if
);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [CG_W-1:0]    r_code;
    logic               r_even;
    logic               r_ind;
    logic               r_rd;
    logic               w_even_nxt;
    logic               w_ind_nxt;
    logic [OCTET_W-1:0] w_enc_data;
    logic               w_enc_k;
    logic [CG_W-1:0]    w_enc_code;
    logic               w_enc_rd;

    encoder_8b10b u_enc (
        .data_in  (w_enc_data),
        .is_k     (w_enc_k),
        .rd_in    (r_rd),
        .code_out (w_enc_code),
        .rd_out   (w_enc_rd)
    );

    // Next-state and encoder selection
    always_comb begin : p_next
        w_state_nxt = r_state;
        w_enc_data  = tx_if.TXD;
        w_enc_k     = 1'b0;
        w_even_nxt  = ~r_even;
        w_ind_nxt   = 1'b1;
        case (r_state)
            ST_GEN: begin
                case (tx_if.tx_o_set)
                    OSET_IDLE: begin
                        w_enc_data  = K28_5_OCTET;
                        w_enc_k     = 1'b1;
                        w_even_nxt  = 1'b1;
                        w_ind_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE_K;
                    end
                    OSET_DATA: begin
                        w_enc_k = 1'b0;
                    end
                    default: begin
                        w_enc_data = oset_k_octet(tx_if.tx_o_set);
                        w_enc_k    = 1'b1;
                    end
                endcase
            end
            ST_IDLE_K: begin
                // K28.5 flipped RD, so RD+ now means it was sent from RD- (/I2/)
                w_enc_data  = r_rd ? D16_2_OCTET : D5_6_OCTET;
                w_even_nxt  = 1'b0;
                w_state_nxt = ST_GEN;
            end
            default: begin
                w_state_nxt = ST_GEN;
            end
        endcase
    end

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin : p_regs
        if (!mr_main_reset) begin
            r_state <= ST_GEN;
            r_code  <= '0;
            r_even  <= 1'b0;
            r_ind   <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_enc_code;
            r_even  <= w_even_nxt;
            r_ind   <= w_ind_nxt;
            r_rd    <= w_enc_rd;
        end
    end

    assign tx_if.tx_code_group    = r_code;
    assign tx_if.tx_even          = r_even;
    assign tx_if.TX_OSET_indicate = r_ind;
    assign tx_if.tx_disparity     = r_rd;

endmodule

// File: tb/tb_tx_code_group_gen.sv
// Self-checking bench for tx_code_group_gen: directed ordered-set sequences
// plus randomized requests against a table-driven 8b/10b sequencer model.
module tb_tx_code_group_gen;

    logic GTX_CLK;
    logic mr_main_reset;
    int   n_tests;
    int   n_fail;

    tx_code_group_gen_if tx_if ();

    tx_code_group_gen u_dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .tx_if         (tx_if)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    // Full 5b/6b and 3b/4b tables, both disparity columns
    logic [5:0] six_n [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    logic [5:0] six_p [0:31] = '{
        6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
        6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
        6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
        6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
    logic [3:0] four_n [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] four_p [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};

    bit         m_rd;
    bit         m_even;
    logic [9:0] cg_a;
    logic [9:0] cg_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Disparity after a sub-block: more ones -> positive, fewer -> negative, equal -> unchanged
    function automatic bit rd_after(input int ones, input int width, input bit rd);
        if (2 * ones > width) return 1'b1;
        if (2 * ones < width) return 1'b0;
        return rd;
    endfunction

    task automatic model_enc(input logic [7:0] d, input bit k, input bit rd,
                             output logic [9:0] cg, output bit rd_o);
        logic [5:0] s6;
        logic [3:0] f4;
        bit         rd_m;
        if (k) begin
            case (d)
                8'hBC:   cg = rd ? 10'h305 : 10'h0FA;
                8'hFB:   cg = rd ? 10'h097 : 10'h368;
                8'hFD:   cg = rd ? 10'h117 : 10'h2E8;
                8'hF7:   cg = rd ? 10'h057 : 10'h3A8;
                default: cg = rd ? 10'h217 : 10'h1E8;
            endcase
            rd_o = rd_after($countones(cg), 10, rd);
        end else begin
            s6   = rd ? six_p[d[4:0]] : six_n[d[4:0]];
            rd_m = rd_after($countones(s6), 6, rd);
            if (d[7:5] == 3'd7 && ((!rd_m && s6[1] && s6[0]) || (rd_m && !s6[1] && !s6[0])))
                f4 = rd_m ? 4'b1000 : 4'b0111;
            else
                f4 = rd_m ? four_p[d[7:5]] : four_n[d[7:5]];
            rd_o = rd_after($countones(f4), 4, rd_m);
            cg   = {s6, f4};
        end
    endtask

    // One clock: predict, advance, compare all four outputs
    task automatic step_check(input logic [7:0] d, input bit k, input bit even_e,
                              input bit ind_e, input string tag, output logic [9:0] obs);
        logic [9:0] cg;
        bit         rd_n;
        model_enc(d, k, m_rd, cg, rd_n);
        @(posedge GTX_CLK);
        @(negedge GTX_CLK);
        check_eq({tag, ".cg"},   32'(tx_if.tx_code_group),    32'(cg));
        check_eq({tag, ".even"}, 32'(tx_if.tx_even),          32'(even_e));
        check_eq({tag, ".ind"},  32'(tx_if.TX_OSET_indicate), 32'(ind_e));
        check_eq({tag, ".rd"},   32'(tx_if.tx_disparity),     32'(rd_n));
        obs    = tx_if.tx_code_group;
        m_rd   = rd_n;
        m_even = even_e;
    endtask

    // Issue one ordered set; during the second half of /I/ the request lines carry junk
    task automatic send(input logic [2:0] oset, input logic [7:0] txd, input logic [2:0] junk);
        bit rd0;
        tx_if.tx_o_set = oset;
        tx_if.TXD      = txd;
        case (oset)
            3'd0: begin
                rd0 = m_rd;
                step_check(8'hBC, 1'b1, 1'b1, 1'b0, "idle_k28_5", cg_a);
                tx_if.tx_o_set = junk;
                tx_if.TXD      = 8'($urandom);
                step_check(rd0 ? 8'hC5 : 8'h50, 1'b0, 1'b0, 1'b1, "idle_second", cg_b);
            end
            3'd1:    step_check(8'hFB, 1'b1, ~m_even, 1'b1, "start", cg_a);
            3'd2:    step_check(txd,   1'b0, ~m_even, 1'b1, "data",  cg_a);
            3'd3:    step_check(8'hFD, 1'b1, ~m_even, 1'b1, "end",   cg_a);
            3'd4:    step_check(8'hF7, 1'b1, ~m_even, 1'b1, "cext",  cg_a);
            default: step_check(8'hFE, 1'b1, ~m_even, 1'b1, "error", cg_a);
        endcase
        tx_if.tx_o_set = oset;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".cg"},   32'(tx_if.tx_code_group),    32'h0);
        check_eq({tag, ".even"}, 32'(tx_if.tx_even),          32'h0);
        check_eq({tag, ".ind"},  32'(tx_if.TX_OSET_indicate), 32'h0);
        check_eq({tag, ".rd"},   32'(tx_if.tx_disparity),     32'h0);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        m_rd           = 1'b0;
        m_even         = 1'b0;
        mr_main_reset  = 1'b0;
        tx_if.tx_o_set = 3'd0;
        tx_if.TXD      = 8'h00;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge GTX_CLK);
        mr_main_reset = 1'b1;

        // Continuous IDLE from RD-: /I2/ every time
        for (int i = 0; i < 3; i++) begin
            send(3'd0, 8'h00, 3'd0);
            check_eq("idle_lit_a", 32'(cg_a), 32'h0FA);
            check_eq("idle_lit_b", 32'(cg_b), 32'h245);
        end

        // Packet: START, four data octets, END, then IDLE
        send(3'd1, 8'h00, 3'd0);
        check_eq("start_lit", 32'(cg_a), 32'h368);
        send(3'd2, 8'h01, 3'd0);
        send(3'd2, 8'h02, 3'd0);
        send(3'd2, 8'h03, 3'd0);
        send(3'd2, 8'h43, 3'd0);
        send(3'd3, 8'h00, 3'd0);
        send(3'd0, 8'h00, 3'd0);

        // D3.0 from RD- leaves RD+, D0.0 keeps RD+, then /I1/
        send(3'd2, 8'h03, 3'd0);
        send(3'd2, 8'h00, 3'd0);
        check_eq("pos_rd_before_idle", 32'(tx_if.tx_disparity), 32'h1);
        send(3'd0, 8'h00, 3'd0);
        check_eq("i1_lit_a", 32'(cg_a), 32'h305);
        check_eq("i1_lit_b", 32'(cg_b), 32'h296);
        check_eq("i1_rd_end", 32'(tx_if.tx_disparity), 32'h0);

        // ERROR and reserved codes
        send(3'd5, 8'h00, 3'd0);
        send(3'd6, 8'h00, 3'd0);
        send(3'd7, 8'h00, 3'd0);

        // START presented during IDLE_K is ignored, then taken next cycle
        send(3'd0, 8'h00, 3'd1);
        send(3'd1, 8'h00, 3'd0);

        // Reset asserted in IDLE_K: outputs clear without a clock edge
        tx_if.tx_o_set = 3'd0;
        step_check(8'hBC, 1'b1, 1'b1, 1'b0, "rst_idle_k28_5", cg_a);
        #2 mr_main_reset = 1'b0;
        #1 check_reset_outputs("rst_in_idle_k");
        @(negedge GTX_CLK);
        check_reset_outputs("rst_held");
        mr_main_reset = 1'b1;
        m_rd   = 1'b0;
        m_even = 1'b0;
        send(3'd0, 8'h00, 3'd0);
        check_eq("post_rst_idle_a", 32'(cg_a), 32'h0FA);

        // Randomized requests
        for (int i = 0; i < 400; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
